// File: rtl/peri_pkg.sv
// Shared definitions for the accumulate/count peripheral and its driver:
// the peripheral opcode set and the driver's state encoding.
package peri_pkg;

   localparam logic [2:0] OP_CLEAR  = 3'd0;
   localparam logic [2:0] OP_ACC    = 3'd1;
   localparam logic [2:0] OP_RD_SUM = 3'd2;
   localparam logic [2:0] OP_RD_CNT = 3'd3;
   localparam logic [2:0] OP_NOP    = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_ACC    = 3'd2,
      ST_RD_SUM = 3'd3,
      ST_RD_CNT = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/peri_acc_driver.sv
// Initiator-side controller for the accumulate/count peripheral.
// A run clears the peripheral, streams up to len words from a valid/ready
// source into it, reads back sum and count, and flags a count mismatch.
module peri_acc_driver
   import peri_pkg::*;
#(
   parameter int DW = 32,
   parameter int LW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [LW-1:0] len,
   input  logic          abort,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [2:0]    opcode,
   output logic [DW-1:0] periwrite,
   input  logic [DW-1:0] periread,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] result_sum,
   output logic [DW-1:0] result_count,
   output logic          count_err,
   output logic          aborted
);

   localparam logic [LW-1:0] ONE_LW  = LW'(1);
   localparam logic [LW-1:0] ZERO_LW = LW'(0);

   state_t        state_q, state_d;
   logic [LW-1:0] remaining_q, remaining_d;
   logic [LW-1:0] sent_q, sent_d;
   logic [DW-1:0] sum_q, sum_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          aborted_q, aborted_d;

   // Next-state, datapath updates and peripheral command decode
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      sent_d      = sent_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      aborted_d   = aborted_q;
      opcode      = OP_NOP;
      periwrite   = '0;
      in_ready    = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               remaining_d = len;
               sent_d      = ZERO_LW;
               err_d       = 1'b0;
               aborted_d   = 1'b0;
               state_d     = ST_CLEAR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            opcode = OP_CLEAR;
            if (remaining_q != ZERO_LW) begin
               state_d = ST_ACC;
            end else begin
               state_d = ST_RD_SUM;
            end
         end
         ST_ACC: begin
            in_ready  = 1'b1;
            // Peripheral samples the word in the same cycle it is accepted
            periwrite = in_data;
            if (in_valid) begin
               opcode      = OP_ACC;
               remaining_d = remaining_q - ONE_LW;
               sent_d      = sent_q + ONE_LW;
               if (remaining_q == ONE_LW) begin
                  state_d = ST_RD_SUM;
               end else begin
                  state_d = ST_ACC;
               end
            end else begin
               opcode = OP_NOP;
            end
            // A coincident word has already been counted above
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = ST_RD_SUM;
            end else begin
               aborted_d = aborted_q;
            end
         end
         ST_RD_SUM: begin
            opcode  = OP_RD_SUM;
            sum_d   = periread;
            state_d = ST_RD_CNT;
         end
         ST_RD_CNT: begin
            opcode  = OP_RD_CNT;
            cnt_d   = periread;
            err_d   = (periread != DW'(sent_q));
            state_d = ST_DONE;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and result registers; reset abandons any run without touching the peripheral
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         sent_q      <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         sent_q      <= sent_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         aborted_q   <= aborted_d;
      end
   end

   assign result_sum   = sum_q;
   assign result_count = cnt_q;
   assign count_err    = err_q;
   assign aborted      = aborted_q;

endmodule

// File: tb/tb_peri_acc_driver.sv
// Bench for peri_acc_driver: a behavioural accumulate/count peripheral is
// wired back-to-back with the driver; each run is predicted from the words
// offered (sum, count, latency, opcode trace) and compared.
module tb_peri_acc_driver;
   import peri_pkg::*;

   localparam int DW = 32;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LW-1:0] len;
   logic          abort;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    opcode;
   logic [DW-1:0] periwrite;
   logic [DW-1:0] periread;
   logic          busy;
   logic          done;
   logic [DW-1:0] result_sum;
   logic [DW-1:0] result_count;
   logic          count_err;
   logic          aborted;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   peri_acc_driver #(.DW(DW), .LW(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .periwrite(periwrite), .periread(periread),
      .busy(busy), .done(done), .result_sum(result_sum),
      .result_count(result_count), .count_err(count_err), .aborted(aborted)
   );

   // Peripheral responder (not affected by rst)
   logic [DW-1:0] p_sum = '0;
   logic [DW-1:0] p_cnt = '0;
   logic          force_cnt = 1'b0;

   always @(posedge clk) begin
      case (opcode)
         OP_CLEAR: begin p_sum <= '0; p_cnt <= '0; end
         OP_ACC:   begin p_sum <= p_sum + periwrite; p_cnt <= p_cnt + 32'd1; end
         default:  begin end
      endcase
   end

   always_comb begin
      periread = '0;
      case (opcode)
         OP_RD_SUM: periread = p_sum;
         OP_RD_CNT: periread = force_cnt ? 32'd7 : p_cnt;
         default:   periread = '0;
      endcase
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Words offered in the next run and idle gap (ready cycles) before each
   logic [31:0] wq[$];
   int          gq[$];

   task automatic do_run(input int n_len, input int abort_idx, input bit ovr, input int mid_start);
      int          idx;
      int          gap_left;
      int          cyc;
      int          done_cyc;
      int          n_sent;
      int          gaps;
      bit          ab;
      logic [31:0] exp_sum;
      logic [31:0] exp_cnt;
      int          opq[$];
      int          expop[$];

      // Reference prediction from the offered stimulus
      n_sent  = (abort_idx >= 0) ? abort_idx + 1 : n_len;
      exp_sum = 32'd0;
      gaps    = 0;
      expop.push_back(0);
      for (int i = 0; i < n_sent; i++) begin
         exp_sum = exp_sum + wq[i];
         gaps    = gaps + gq[i];
         for (int g = 0; g < gq[i]; g++) expop.push_back(4);
         expop.push_back(1);
      end
      expop.push_back(2);
      expop.push_back(3);
      expop.push_back(4);
      exp_cnt = ovr ? 32'd7 : 32'(n_sent);

      idx      = 0;
      ab       = 1'b0;
      cyc      = 0;
      done_cyc = -1;
      gap_left = (wq.size() > 0) ? gq[0] : 0;
      force_cnt = ovr;

      @(negedge clk);
      start = 1'b1;
      len   = n_len[LW-1:0];
      while (cyc < 200) begin
         @(negedge clk);
         cyc++;
         start    = (cyc == mid_start);
         if (start) len = 16'd9;
         in_valid = (idx < wq.size()) && (gap_left == 0) && !ab;
         in_data  = in_valid ? wq[idx] : $urandom;
         abort    = in_valid && (idx == abort_idx);
         #1;
         opq.push_back(int'(opcode));
         check_val("busy_run", {31'd0, busy}, 32'd1);
         if (in_ready && in_valid) begin
            idx++;
            if (abort) ab = 1'b1;
            if (idx < wq.size()) gap_left = gq[idx];
         end else if (in_ready && gap_left > 0) begin
            gap_left--;
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
      end
      start = 1'b0; in_valid = 1'b0; abort = 1'b0;

      check_val("done_latency", 32'(done_cyc), 32'(4 + n_sent + gaps));
      check_val("op_trace_len", 32'(opq.size()), 32'(expop.size()));
      if (opq.size() == expop.size()) begin
         for (int i = 0; i < opq.size(); i++) check_val("op_trace", 32'(opq[i]), 32'(expop[i]));
      end
      check_val("result_sum", result_sum, exp_sum);
      check_val("result_count", result_count, exp_cnt);
      check_val("count_err", {31'd0, count_err}, {31'd0, (exp_cnt != 32'(n_sent))});
      check_val("aborted", {31'd0, aborted}, {31'd0, (abort_idx >= 0)});

      // Back in idle: flags held, and no second done
      @(negedge clk); #1;
      check_val("busy_idle", {31'd0, busy}, 32'd0);
      check_val("aborted_held", {31'd0, aborted}, {31'd0, (abort_idx >= 0)});
      check_val("err_held", {31'd0, count_err}, {31'd0, (exp_cnt != 32'(n_sent))});
      for (int i = 0; i < 4; i++) begin
         check_val("no_extra_done", {31'd0, done}, 32'd0);
         @(negedge clk); #1;
      end
      force_cnt = 1'b0;
   endtask

   initial begin
      int n;
      int ai;
      bit ov;
      rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; in_data = '0; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("rst_opcode", {29'd0, opcode}, 32'd4);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_done", {31'd0, done}, 32'd0);
      check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check_val("rst_sum", result_sum, 32'd0);
      check_val("rst_flags", {30'd0, count_err, aborted}, 32'd0);

      // Basic run
      wq = '{32'd5, 32'd7, 32'd9}; gq = '{0, 0, 0};
      do_run(3, -1, 1'b0, 0);
      // Stall of three cycles between words
      wq = '{32'h10, 32'h20}; gq = '{0, 3};
      do_run(2, -1, 1'b0, 0);
      // Zero length after a non-zero run
      wq.delete(); gq.delete();
      do_run(0, -1, 1'b0, 0);
      // Abort coinciding with the third word
      wq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5}; gq = '{0, 0, 0, 0, 0};
      do_run(5, 2, 1'b0, 0);
      // Sum wrap and a start pulse while busy
      wq = '{32'hFFFF_FFFF, 32'd2}; gq = '{0, 0};
      do_run(2, -1, 1'b0, 2);

      // Reset during ACC after two words
      @(negedge clk);
      start = 1'b1; len = 16'd5; in_valid = 1'b1; in_data = 32'd11;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); rst = 1'b1; in_valid = 1'b0;
      @(negedge clk); rst = 1'b0; #1;
      check_val("mid_rst_opcode", {29'd0, opcode}, 32'd4);
      check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
      check_val("mid_rst_sum", result_sum, 32'd0);
      check_val("mid_rst_count", result_count, 32'd0);
      check_val("mid_rst_flags", {29'd0, count_err, aborted, in_ready}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         check_val("mid_rst_no_done", {30'd0, done, busy}, 32'd0);
         @(negedge clk); #1;
      end

      // Count read-back forced wrong
      wq = '{32'd4, 32'd4}; gq = '{0, 0};
      do_run(2, -1, 1'b1, 0);

      // Randomized runs
      for (int r = 0; r < 20; r++) begin
         n = $urandom_range(0, 6);
         wq.delete(); gq.delete();
         for (int i = 0; i < n; i++) begin
            wq.push_back($urandom);
            gq.push_back($urandom_range(0, 2));
         end
         ai = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
         ov = ($urandom_range(0, 4) == 0);
         do_run(n, ai, ov, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
